mem_write_checker: RTL
======================

# mem_write_checker

Synthesisable successor to the processor self-check: watches the data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) of the `top` core and decides pass/fail in hardware, so the same check runs in simulation and on FPGA. Generalised to a parameterised pass address/value, a list of N permitted intermediate store addresses, a cycle timeout, write counting and an optional write-log FIFO. It sits beside `top` and drives status LEDs or a bench.

## Interface
- `WIDTH`, 32, address/data width
- `PASS_ADR`, 100, store address that ends the test
- `PASS_DATA`, 1, value required at `PASS_ADR` for pass
- `NUM_ALLOW`, 2, number of permitted non-terminal store addresses (1..8)
- `ALLOW_ADRS`, {32'd36, 32'd96}, packed NUM_ALLOW×WIDTH list; entry i at bits [i*WIDTH +: WIDTH]
- `TIMEOUT`, 1024, cycles in RUN before timeout; 0 disables
- `CNT_W`, 16, width of write counter
- `LOG_DEPTH`, 8, log FIFO entries (power of two ≥ 2)
- `clk` in 1 — rising-edge clock
- `reset` in 1 — synchronous, active-high
- `MemWrite` in 1 — store strobe from core
- `DataAdr` in WIDTH — store address
- `WriteData` in WIDTH — store data
- `done` out 1 — verdict reached (state ≠ RUN)
- `pass` out 1 — state PASS
- `fail` out 1 — state FAIL
- `timeout` out 1 — state TOUT
- `write_count` out CNT_W — stores seen in RUN, saturating
- `fail_adr`, `fail_data` out WIDTH — offending store captured on FAIL
- `log_valid` out 1, `log_ready` in 1, `log_adr`/`log_data` out WIDTH, `log_ovf` out 1 — log port (see Configuration)

## Operation
- States: RUN (reset state), PASS, FAIL, TOUT. PASS/FAIL/TOUT are sticky until `reset`.
- In RUN, each cycle with `MemWrite`=1 classifies the store, in priority order:
  - `DataAdr`==PASS_ADR and `WriteData`==PASS_DATA → PASS.
  - `DataAdr` matches any ALLOW_ADRS entry (and ≠ PASS_ADR) → stay RUN.
  - otherwise (including PASS_ADR with wrong data) → FAIL; latch `fail_adr`/`fail_data`.
- `write_count` increments on every store classified in RUN (terminal store included); saturates at 2^CNT_W−1; stores after verdict ignored.
- Timeout counter counts cycles in RUN; when it reaches TIMEOUT−1 with no terminal store that cycle → TOUT. A terminal store in the same cycle wins over timeout.
- Reset values: state RUN; `done`,`pass`,`fail`,`timeout`,`log_valid`,`log_ovf` = 0; `write_count`,`fail_adr`,`fail_data`, timeout counter, FIFO pointers = 0.
- Reset asserted mid-test (any state) returns to RUN next edge with all above cleared; a store in a reset cycle is ignored.

## Timing
- Inputs sampled on rising `clk`; verdict outputs are registered, valid the cycle after the deciding store (1-cycle latency).
- `write_count`, `fail_*` update on the same edge as the state.
- Log: store pushed on its sampling edge; `log_valid` rises next cycle; entry popped on edge where `log_valid && log_ready`. Head data stable while `log_valid && !log_ready`.
- Log full and push without pop: store dropped, `log_ovf` set (sticky until reset). Full with simultaneous pop and push: both occur, no overflow. Empty with push: no pop same cycle (no fall-through).

## Configuration
- `MEM_WRITE_CHECKER_LOG_EN` defined: log FIFO built; every store classified in RUN is pushed.
- Undefined: no FIFO storage; `log_valid`=0, `log_ovf`=0, `log_adr`=`log_data`=0, `log_ready` ignored. Checking behaviour identical.

## Test plan
- Stores 36←7, 96←3, then 100←1 → `pass`=1 one cycle later, `write_count`=3, `fail`=0.
- Store 100←5 → `fail`=1, `fail_adr`=100, `fail_data`=5; later 100←1 leaves state FAIL, `write_count`=1.
- Store 44←1 → `fail`=1, `fail_adr`=44; TIMEOUT=16 with no stores → `timeout`=1 after 16 cycles; store 100←1 on cycle 15 → `pass`, not timeout.
- Reset pulsed after PASS → all outputs 0, state RUN; store during reset cycle not counted.
- LOG_EN, LOG_DEPTH=4, `log_ready`=0, 5 allowed stores → 4 logged, `log_ovf`=1; drain with `log_ready`=1 → entries in order 36/96 data match.
- LOG_EN, FIFO full, push and pop same cycle → no overflow, occupancy stays 4.

Source files
------------

// File: rtl/mem_write_checker.sv
// mem_write_checker: watches the core's data-memory write port and reaches a
// pass / fail / timeout verdict in hardware. Optional write-log FIFO is built
// when MEM_WRITE_CHECKER_LOG_EN is defined; otherwise the log port is tied off.
module mem_write_checker #(
  parameter int unsigned              WIDTH      = 32,
  parameter logic [WIDTH-1:0]         PASS_ADR   = WIDTH'(100),
  parameter logic [WIDTH-1:0]         PASS_DATA  = WIDTH'(1),
  parameter int unsigned              NUM_ALLOW  = 2,
  parameter logic [NUM_ALLOW*WIDTH-1:0] ALLOW_ADRS = (NUM_ALLOW*WIDTH)'({32'd36, 32'd96}),
  parameter int unsigned              TIMEOUT    = 1024,
  parameter int unsigned              CNT_W      = 16,
  parameter int unsigned              LOG_DEPTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] write_count,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [WIDTH-1:0] log_adr,
  output logic [WIDTH-1:0] log_data,
  output logic             log_ovf
);

  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TOUT} state_t;

  state_t          state, state_d;
  logic [TO_W-1:0] tcnt;
  logic            store;
  logic            hit_pass;
  logic            hit_allow;
  logic            to_hit;
  logic            fail_cap;

  // Classify the current store against the pass address and the allow list
  always_comb begin
    store     = (state == ST_RUN) && MemWrite;
    hit_pass  = (DataAdr == PASS_ADR) && (WriteData == PASS_DATA);
    hit_allow = 1'b0;
    for (int i = 0; i < int'(NUM_ALLOW); i++) begin
      if (DataAdr == ALLOW_ADRS[i*WIDTH +: WIDTH]) hit_allow = 1'b1;
    end
    // PASS_ADR with wrong data is never tolerated, even if listed
    hit_allow = hit_allow && (DataAdr != PASS_ADR);
    to_hit    = (TIMEOUT != 0) && (tcnt == TO_LAST);
  end

  // Next-state: a terminal store in the same cycle beats the timeout
  always_comb begin
    state_d  = state;
    fail_cap = 1'b0;
    case (state)
      ST_RUN: begin
        if (store) begin
          if (hit_pass) begin
            state_d = ST_PASS;
          end else if (!hit_allow) begin
            state_d  = ST_FAIL;
            fail_cap = 1'b1;
          end
        end
        if ((state_d == ST_RUN) && to_hit) state_d = ST_TOUT;
      end
      default: state_d = state;
    endcase
  end

  // State, verdict outputs, counters and failure capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      write_count <= '0;
      fail_adr    <= '0;
      fail_data   <= '0;
      tcnt        <= '0;
    end else begin
      state   <= state_d;
      done    <= (state_d != ST_RUN);
      pass    <= (state_d == ST_PASS);
      fail    <= (state_d == ST_FAIL);
      timeout <= (state_d == ST_TOUT);
      if (store && (write_count != {CNT_W{1'b1}})) write_count <= write_count + CNT_W'(1);
      if (fail_cap) begin
        fail_adr  <= DataAdr;
        fail_data <= WriteData;
      end
      if ((state == ST_RUN) && (TIMEOUT != 0)) tcnt <= tcnt + TO_W'(1);
    end
  end

`ifdef MEM_WRITE_CHECKER_LOG_EN
  localparam int unsigned LOG_AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [WIDTH-1:0]  mem_adr  [LOG_DEPTH];
  logic [WIDTH-1:0]  mem_data [LOG_DEPTH];
  logic [LOG_AW-1:0] wr_ptr, rd_ptr;
  logic [LOG_AW:0]   occ, occ_d;
  logic              pop, push, full;

  // FIFO handshake: a pop frees a slot for a same-cycle push when full
  always_comb begin
    pop   = log_valid && log_ready;
    full  = (occ == (LOG_AW+1)'(LOG_DEPTH));
    push  = store && (!full || pop);
    occ_d = occ;
    if (push && !pop) occ_d = occ + (LOG_AW+1)'(1);
    if (pop && !push) occ_d = occ - (LOG_AW+1)'(1);
  end

  // Log storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_adr[wr_ptr]  <= DataAdr;
      mem_data[wr_ptr] <= WriteData;
    end
  end

  // Pointers, occupancy, valid and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      log_valid <= 1'b0;
      log_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG_AW'(1);
      occ       <= occ_d;
      log_valid <= (occ_d != '0);
      if (store && full && !pop) log_ovf <= 1'b1;
    end
  end

  assign log_adr  = mem_adr[rd_ptr];
  assign log_data = mem_data[rd_ptr];
`else
  wire unused_log_ready = log_ready;

  assign log_valid = 1'b0;
  assign log_ovf   = 1'b0;
  assign log_adr   = '0;
  assign log_data  = '0;
`endif

endmodule
